// File: rtl/gcd_req_arbiter.sv
// gcd_req_arbiter: round-robin front end sharing one iterative GCD unit among NREQ requesters
module gcd_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int WIDTH   = 41,
  parameter int TIMEOUT = 1024,
  parameter int GUARD   = 2
) (
  input  logic                     clk_i,
  input  logic                     reset_i,
  input  logic [NREQ-1:0]          req_valid_i,
  input  logic [NREQ*WIDTH-1:0]    req_a_i,
  input  logic [NREQ*WIDTH-1:0]    req_b_i,
  output logic [NREQ-1:0]          req_ready_o,
  output logic                     resp_valid_o,
  input  logic                     resp_ready_i,
  output logic [$clog2(NREQ)-1:0]  resp_id_o,
  output logic [WIDTH-1:0]         resp_res_o,
  output logic                     resp_timeout_o,
  output logic                     unit_start_o,
  output logic [WIDTH-1:0]         unit_a_o,
  output logic [WIDTH-1:0]         unit_b_o,
  output logic                     unit_reset_o,
  input  logic [WIDTH-1:0]         unit_res_i,
  input  logic                     unit_done_i
);
  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(TIMEOUT + GUARD + 1);
  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_GUARD, S_WAIT, S_RESP} state_t;
  state_t            state_q, state_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d, resp_id_q, resp_id_d, grant, idx;
  logic              found, resp_timeout_q, resp_timeout_d, abort_q, abort_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  unit_a_q, unit_a_d, unit_b_q, unit_b_d, resp_res_q, resp_res_d;
  // Scan from farthest to nearest so the requester right after rr_ptr wins
  always_comb begin
    grant = '0;
    found = 1'b0;
    idx   = '0;
    for (int k = NREQ; k >= 1; k--) begin
      idx = IW'((int'(rr_ptr_q) + k) % NREQ);
      if (req_valid_i[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end
  always_comb begin
    state_d        = state_q;
    rr_ptr_d       = rr_ptr_q;
    cnt_d          = cnt_q;
    unit_a_d       = unit_a_q;
    unit_b_d       = unit_b_q;
    resp_id_d      = resp_id_q;
    resp_res_d     = resp_res_q;
    resp_timeout_d = resp_timeout_q;
    abort_d        = 1'b0;
    case (state_q)
      S_IDLE: if (found) begin
        state_d   = S_ISSUE;
        rr_ptr_d  = grant;
        resp_id_d = grant;
        unit_a_d  = req_a_i[int'(grant)*WIDTH +: WIDTH];
        unit_b_d  = req_b_i[int'(grant)*WIDTH +: WIDTH];
      end
      S_ISSUE: begin
        state_d = S_GUARD;
        cnt_d   = '0;
      end
      // The unit still shows the previous done right after start; skip it
      S_GUARD: begin
        cnt_d   = (cnt_q == CW'(GUARD - 1)) ? '0 : cnt_q + 1'b1;
        state_d = (cnt_q == CW'(GUARD - 1)) ? S_WAIT : S_GUARD;
      end
      S_WAIT: if (unit_done_i) begin
        state_d        = S_RESP;
        resp_res_d     = unit_res_i;
        resp_timeout_d = 1'b0;
      end else if (cnt_q == CW'(TIMEOUT - 1)) begin
        state_d        = S_RESP;
        resp_res_d     = '0;
        resp_timeout_d = 1'b1;
        abort_d        = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
      S_RESP: state_d = resp_ready_i ? S_IDLE : S_RESP;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q        <= S_IDLE;
      rr_ptr_q       <= IW'(NREQ - 1);
      cnt_q          <= '0;
      unit_a_q       <= '0;
      unit_b_q       <= '0;
      resp_id_q      <= '0;
      resp_res_q     <= '0;
      resp_timeout_q <= 1'b0;
      abort_q        <= 1'b0;
    end else begin
      state_q        <= state_d;
      rr_ptr_q       <= rr_ptr_d;
      cnt_q          <= cnt_d;
      unit_a_q       <= unit_a_d;
      unit_b_q       <= unit_b_d;
      resp_id_q      <= resp_id_d;
      resp_res_q     <= resp_res_d;
      resp_timeout_q <= resp_timeout_d;
      abort_q        <= abort_d;
    end
  end
  assign req_ready_o    = (state_q == S_IDLE && found) ? NREQ'(1) << grant : '0;
  assign resp_valid_o   = state_q == S_RESP;
  assign resp_id_o      = resp_id_q;
  assign resp_res_o     = resp_res_q;
  assign resp_timeout_o = resp_timeout_q;
  assign unit_start_o   = state_q == S_ISSUE;
  assign unit_a_o       = unit_a_q;
  assign unit_b_o       = unit_b_q;
  assign unit_reset_o   = reset_i | abort_q;
endmodule

// File: tb/tb_gcd_req_arbiter.sv
// tb_gcd_req_arbiter: directed and random requests against a stand-in GCD unit and a round-robin/gcd reference
module tb_gcd_req_arbiter;
  localparam int N = 4, W = 41, TO = 16, G = 2;
  logic clk = 1'b0;
  logic reset;
  logic [N-1:0] req_valid, req_ready;
  logic [N*W-1:0] req_a, req_b;
  logic resp_valid, resp_ready, resp_timeout, unit_start, unit_reset, unit_done;
  logic [1:0] resp_id;
  logic [W-1:0] resp_res, unit_a, unit_b, unit_res;
  int vectors = 0, miscompares = 0, exp_ptr = N - 1, unit_lat = 0;
  bit unit_hang = 1'b0;
  always #5 clk = ~clk;
  gcd_req_arbiter #(.NREQ(N), .WIDTH(W), .TIMEOUT(TO), .GUARD(G)) dut (
    .clk_i(clk), .reset_i(reset), .req_valid_i(req_valid), .req_a_i(req_a), .req_b_i(req_b),
    .req_ready_o(req_ready), .resp_valid_o(resp_valid), .resp_ready_i(resp_ready),
    .resp_id_o(resp_id), .resp_res_o(resp_res), .resp_timeout_o(resp_timeout),
    .unit_start_o(unit_start), .unit_a_o(unit_a), .unit_b_o(unit_b), .unit_reset_o(unit_reset),
    .unit_res_i(unit_res), .unit_done_i(unit_done)
  );
  function automatic logic [W-1:0] gcd(input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction
  // Unit stand-in: done stays high (stale) one cycle past start, then result after unit_lat cycles
  logic busy, first;
  int k_left;
  logic [W-1:0] ua, ub;
  always @(posedge clk) begin
    if (unit_reset) begin
      unit_done <= 1'b0;
      unit_res  <= '0;
      busy      <= 1'b0;
      first     <= 1'b0;
    end else if (unit_start) begin
      ua     <= unit_a;
      ub     <= unit_b;
      busy   <= 1'b1;
      first  <= 1'b1;
      k_left <= unit_lat;
    end else if (busy) begin
      if (first) begin
        unit_done <= 1'b0;
        first     <= 1'b0;
      end else if (!unit_hang) begin
        if (k_left == 0) begin
          unit_done <= 1'b1;
          unit_res  <= gcd(ua, ub);
          busy      <= 1'b0;
        end else k_left <= k_left - 1;
      end
    end
  end
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b);
    req_a[i*W +: W] = a;
    req_b[i*W +: W] = b;
  endtask
  task automatic txn(input int hold, input bit drop, input bit keep);
    int g, n, starts, readies, resets;
    logic [W-1:0] ea, eb, er;
    bit ok;
    g = -1;
    for (int k = 1; k <= N && g < 0; k++) if (req_valid[(exp_ptr + k) % N]) g = (exp_ptr + k) % N;
    n = 0;
    #1;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("grant", 64'(req_ready), 64'(1) << g);
    ea = req_a[g*W +: W];
    eb = req_b[g*W +: W];
    er = unit_hang ? '0 : gcd(ea, eb);
    @(negedge clk);
    chk("start", 64'(unit_start), 64'd1);
    chk("unit_a", 64'(unit_a), 64'(ea));
    chk("unit_b", 64'(unit_b), 64'(eb));
    if (drop) req_valid[g] = 1'b0;
    n = 0;
    starts = 0;
    readies = 0;
    resets = 0;
    while (!resp_valid && n < TO + 40) begin
      @(negedge clk);
      n++;
      starts += int'(unit_start);
      readies += int'(|req_ready);
      resets += int'(unit_reset);
    end
    chk("latency", 64'(n), unit_hang ? 64'(TO + G + 1) : 64'(G + 2 + unit_lat));
    chk("extra_start", 64'(starts), 64'd0);
    chk("ready_in_op", 64'(readies), 64'd0);
    chk("unit_reset_pulses", 64'(resets), 64'(unit_hang));
    chk("resp_id", 64'(resp_id), 64'(g));
    chk("resp_res", 64'(resp_res), 64'(er));
    chk("resp_timeout", 64'(resp_timeout), 64'(unit_hang));
    ok = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      ok &= resp_valid && resp_id == 2'(g) && resp_res == er && resp_timeout == unit_hang
            && req_ready == '0 && !unit_start;
    end
    if (hold > 0) chk("hold_stable", 64'(ok), 64'd1);
    resp_ready = 1'b1;
    @(negedge clk);
    chk("resp_drop", 64'(resp_valid), 64'd0);
    resp_ready = keep;
    exp_ptr = g;
    unit_hang = 1'b0;
  endtask
  initial begin
    int n, seen;
    logic [W-1:0] f, x, y;
    reset = 1'b1;
    req_valid = '0;
    req_a = '0;
    req_b = '0;
    resp_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 64'd0);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_id", 64'(resp_id), 64'd0);
    chk("rst_resp_res", 64'(resp_res), 64'd0);
    chk("rst_unit_start", 64'(unit_start), 64'd0);
    chk("rst_unit_a", 64'(unit_a), 64'd0);
    chk("rst_unit_reset", 64'(unit_reset), 64'd1);
    reset = 1'b0;
    @(negedge clk);
    chk("unit_reset_low", 64'(unit_reset), 64'd0);
    set_req(1, 41'd5, 41'd0);
    req_valid = 4'b0010;
    txn(0, 1, 0);
    set_req(1, 41'd7, 41'd7);
    req_valid[1] = 1'b1;
    txn(0, 1, 0);
    set_req(0, 41'd5, 41'd0);
    req_valid[0] = 1'b1;
    txn(0, 1, 0);
    set_req(0, 41'd9, 41'd9);
    req_valid[0] = 1'b1;
    txn(0, 1, 0);
    unit_hang = 1'b1;
    req_valid = 4'b0100;
    n = 0;
    #1;
    while (req_ready == '0 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("mid_grant", 64'(req_ready), 64'b0100);
    repeat (6) @(negedge clk);
    reset = 1'b1;
    req_valid = '0;
    #1;
    chk("mid_unit_reset", 64'(unit_reset), 64'd1);
    @(negedge clk);
    reset = 1'b0;
    #1;
    chk("post_rst_outputs", 64'({req_ready, resp_valid, resp_id, resp_timeout, unit_start, unit_reset}), 64'd0);
    chk("post_rst_res", 64'(resp_res), 64'd0);
    chk("post_rst_unit_ab", 64'(unit_a | unit_b), 64'd0);
    seen = 0;
    repeat (25) begin
      @(negedge clk);
      seen += int'(resp_valid);
    end
    chk("no_resp_after_rst", 64'(seen), 64'd0);
    exp_ptr = N - 1;
    unit_hang = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 41'(i + 1), 41'd0);
    req_valid = 4'hF;
    resp_ready = 1'b1;
    repeat (5) txn(0, 0, 1);
    resp_ready = 1'b0;
    unit_lat = 2;
    txn(10, 1, 0);
    unit_lat = 0;
    unit_hang = 1'b1;
    txn(0, 1, 0);
    req_valid = 4'b0001;
    set_req(0, 41'd12, 41'd18);
    txn(0, 1, 0);
    for (int r = 0; r < 40; r++) begin
      for (int i = 0; i < N; i++) begin
        f = 41'($urandom_range(1, 1000));
        x = 41'($urandom_range(0, 32'h3FFF_FFFF));
        y = 41'($urandom_range(0, 32'h3FFF_FFFF));
        set_req(i, f * x, f * y);
      end
      req_valid = 4'($urandom_range(1, 15));
      unit_lat = $urandom_range(0, 3);
      unit_hang = ($urandom_range(0, 9) == 0);
      resp_ready = 1'b0;
      txn($urandom_range(0, 3), 1'($urandom_range(0, 1)), 1'b0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/gcd_req_arbiter.md
Name: gcd_req_arbiter

Overview:
- Shares one iterative GCD datapath unit (start/a/b in, res/done out, 41-bit operands) between NREQ requesters.
- Round-robin arbitration of operand requests, sequencing of the unit's start pulse, masking of the unit's stale done, capture of the result, and return of a tagged response.
- Watchdog aborts a hung operation by pulsing the unit's reset.
- Sits between requester logic and a single unit instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- WIDTH, 41, operand/result width; matches the unit.
- TIMEOUT, 1024, max WAIT cycles before abort (>= 4).
- GUARD, 2, cycles after start during which unit_done is ignored.

Ports:
- clk  in  1  clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NREQ  per-requester request valid.
- req_a  in  NREQ*WIDTH  operand a; slice i is [i*WIDTH +: WIDTH].
- req_b  in  NREQ*WIDTH  operand b; same slicing.
- req_ready  out  NREQ  one-hot accept pulse.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response accept.
- resp_id  out  $clog2(NREQ)  index of the requester served.
- resp_res  out  WIDTH  result.
- resp_timeout  out  1  operation aborted; resp_res=0.
- unit_start  out  1  start pulse to unit.
- unit_a  out  WIDTH  latched operand a to unit.
- unit_b  out  WIDTH  latched operand b to unit.
- unit_reset  out  1  unit reset = reset OR abort pulse.
- unit_res  in  WIDTH  unit result.
- unit_done  in  1  unit done; level, stays high after completion.

Behaviour:
- Reset values:
  - state=IDLE, rr_ptr=NREQ-1.
  - req_ready=0, resp_valid=0, resp_id=0, resp_res=0, resp_timeout=0.
  - unit_start=0, unit_a=0, unit_b=0.
  - Counters cleared; unit_reset=1 while reset=1.
- FSM states: IDLE, ISSUE, GUARD, WAIT, RESP.
- IDLE:
  - Grant = first i with req_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... modulo NREQ.
  - Combinationally assert req_ready[grant] only (one-hot, never more than one bit).
  - At the edge: latch unit_a/unit_b from slice grant, latch grant into resp_id, set rr_ptr=grant, go to ISSUE.
  - No valid request: stay in IDLE, req_ready=0.
- ISSUE: unit_start=1 for exactly this one cycle; go to GUARD, guard counter=0.
- GUARD:
  - unit_done ignored for GUARD cycles, because the unit raises a stale done the cycle after start.
  - Then go to WAIT with watchdog=0.
- WAIT:
  - If unit_done=1: capture unit_res into resp_res, resp_timeout=0, go to RESP.
  - Else increment the watchdog.
  - When watchdog reaches TIMEOUT-1 without done: unit_reset=1 for one cycle, resp_res=0, resp_timeout=1, go to RESP.
- RESP:
  - resp_valid=1; resp_id, resp_res and resp_timeout held stable until resp_valid && resp_ready.
  - On handshake, go to IDLE; resp_valid drops the next cycle.
  - The next grant occurs no earlier than the IDLE cycle after.
- Latency: request accepted at cycle T → unit_start at T+1 → first done sample at T+2+GUARD → resp_valid at the cycle after done is sampled. Minimum T+5 with GUARD=2.
- Requester rules:
  - A requester must hold req_valid and its operands until req_ready.
  - Deasserting req_valid before grant is permitted; no grant results.
- Fairness: the granted requester becomes lowest priority. With all NREQ requesting continuously, the grant order is 0,1,2,...,NREQ-1,0,...
- Operands are passed unmodified. No width conversion; resp_res is exactly unit_res.
- Reset in any state:
  - Returns to IDLE next cycle; an in-flight operation is discarded with no response.
  - unit_reset is asserted; rr_ptr=NREQ-1.
- resp_ready=1 while not in RESP has no effect.
- unit_done high during IDLE, ISSUE or GUARD has no effect.

Test Plan:
- Single request: reset, requester 1 with a=5, b=0 → req_ready=4'b0010 one cycle; unit_start one cycle later; resp_valid with resp_id=1, resp_res=5, resp_timeout=0. Also a=7, b=7 → resp_res=7.
- Stale done mask: back-to-back ops, first a=5,b=0, then a=9,b=9 → second response resp_res=9, not 5. The false done at start+1 must not terminate the op.
- Round-robin: all 4 requesters valid continuously with a=i+1, b=0 → grant order 0,1,2,3,0; resp_res 1,2,3,4,1 with matching resp_id.
- Backpressure: hold resp_ready=0 for 10 cycles → resp_valid, resp_id and resp_res stable; no req_ready pulses; accept proceeds after resp_ready=1.
- Timeout: bench stub holds unit_done=0, TIMEOUT=16 → unit_reset pulses once; resp_timeout=1, resp_res=0; the next request is served normally.
- Reset mid-op: assert reset during WAIT → no response emitted; state=IDLE and all outputs at reset values the cycle after reset deasserts.
